// File: rtl/delay_seq_pkg.sv
// Shared types and helpers for the a ##d b stimulus generator.
//   state_e      : sequencer phases
//   clamp_delay  : maps a requested distance onto 1..max_delay
package delay_seq_pkg;

    localparam int unsigned DEFAULT_MAX_DELAY = 8;
    localparam int unsigned DEFAULT_DELAY_W   = $clog2(DEFAULT_MAX_DELAY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        A_PH = 2'd1,
        WAIT = 2'd2,
        B_PH = 2'd3
    } state_e;

    // Zero distance is meaningless for a ##d b, so it collapses to 1.
    function automatic int unsigned clamp_delay(input int unsigned req_delay,
                                                input int unsigned max_delay);
        if (req_delay == 0)
            return 1;
        if (req_delay > max_delay)
            return max_delay;
        return req_delay;
    endfunction

endpackage

// File: rtl/delay_seq_driver_if.sv
// Request/pattern bundle of delay_seq_driver.
//   start, delay, a_hold : request side (driven by master)
//   a, b, busy, done     : generated pattern and status (driven by slave)
interface delay_seq_driver_if
    import delay_seq_pkg::*;
#(
    parameter int unsigned DELAY_W = DEFAULT_DELAY_W
);

    logic               start;
    logic [DELAY_W-1:0] delay;
    logic               a_hold;
    logic               a;
    logic               b;
    logic               busy;
    logic               done;

    modport master (
        output start, delay, a_hold,
        input  a, b, busy, done
    );

    modport slave (
        input  start, delay, a_hold,
        output a, b, busy, done
    );

endinterface

// File: rtl/delay_down_counter.sv
// Loadable down-counter timing the WAIT phase.
//   clk, rst_n : parent clock / async active-low reset
//   load       : load load_val (takes priority over en)
//   en         : decrement by one
//   cnt        : current count
//   at_one     : count equals 1 (last WAIT cycle)
module delay_down_counter
    import delay_seq_pkg::*;
#(
    parameter int unsigned DELAY_W = DEFAULT_DELAY_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    input  logic               en,
    output logic [DELAY_W-1:0] cnt,
    output logic               at_one
);

    logic [DELAY_W-1:0] cnt_q;
    logic [DELAY_W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en)
            cnt_d = cnt_q - DELAY_W'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt    = cnt_q;
    assign at_one = (cnt_q == DELAY_W'(1));

endmodule

// File: rtl/delay_seq_driver.sv
// Generates the a ##d b pattern: a in the cycle after start, one-cycle b
// d cycles later, done one cycle after b. d and a_hold latched at start.
//   clk, rst_n : clock / async active-low reset
//   bus        : delay_seq_driver_if slave (start/delay/a_hold in,
//                a/b/busy/done out, all outputs registered)
module delay_seq_driver
    import delay_seq_pkg::*;
#(
    parameter int unsigned MAX_DELAY = DEFAULT_MAX_DELAY,
    parameter int unsigned DELAY_W   = $clog2(MAX_DELAY + 1)
) (
    input  logic clk,
    input  logic rst_n,
    delay_seq_driver_if.slave bus
);

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic               hold_q, hold_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_load;
    logic               cnt_en;
    logic [DELAY_W-1:0] cnt_val;
    logic [DELAY_W-1:0] cnt;
    logic               cnt_at_one;

    delay_down_counter #(
        .DELAY_W (DELAY_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .cnt      (cnt),
        .at_one   (cnt_at_one)
    );

    // Next state, latched request and next output values
    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        hold_d   = hold_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        // Counter holds d-1 on entry to WAIT so at_one marks the last WAIT cycle
        cnt_val  = dly_q - DELAY_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dly_d   = DELAY_W'(clamp_delay(32'(bus.delay), MAX_DELAY));
                    hold_d  = bus.a_hold;
                    state_d = A_PH;
                end
            end
            A_PH: begin
                if (dly_q == DELAY_W'(1)) begin
                    state_d = B_PH;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_at_one)
                    state_d = B_PH;
                else
                    cnt_en = (cnt != '0);
            end
            B_PH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are registered
        a_d    = (state_d == A_PH) || ((state_d == WAIT) && hold_d);
        b_d    = (state_d == B_PH);
        busy_d = (state_d != IDLE);
        done_d = (state_q == B_PH);
    end

    // State, request and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dly_q   <= DELAY_W'(1);
            hold_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            hold_q  <= hold_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: doc/delay_seq_driver.md
# delay_seq_driver

Stimulus generator that produces the `a ##d b` temporal pattern on two single-bit outputs. On a start request it drives `a`, waits a programmable number of cycles, then drives a one-cycle `b`. It sits upstream of the sequence monitors and cover/assume properties in the delay-operator examples, giving formal and simulation benches a deterministic, parameterised source of matching traffic.

## Interface
- `MAX_DELAY`, 8: largest supported `a`-to-`b` distance in cycles; must be ≥ 1.
- `DELAY_W`, `$clog2(MAX_DELAY+1)`: width of the `delay` input.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request one sequence; sampled only in IDLE.
- `delay`  in  DELAY_W  requested distance d; sampled with `start`.
- `a_hold`  in  1  0: `a` is a one-cycle pulse; 1: `a` is held from the A cycle through the last WAIT cycle; sampled with `start`.
- `a`  out  1  sequence head.
- `b`  out  1  sequence tail.
- `busy`  out  1  sequence in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse after `b`.

## Operation
- All outputs are registered. Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- States:
  - IDLE: `start`=1 latches d and `a_hold`, then goes to A_PH.
  - A_PH: `a`=1 for one cycle. Goes to B_PH if d=1, else to WAIT with counter=d-1.
  - WAIT: counter decrements each cycle; `a`=`a_hold`. Goes to B_PH on the cycle the counter reaches 1.
  - B_PH: `b`=1, `a`=0. Goes to IDLE.
- Effective d is clamped to the range 1..MAX_DELAY:
  - `delay`=0 is treated as 1.
  - `delay`>MAX_DELAY is treated as MAX_DELAY.
- `busy` is high in A_PH, WAIT and B_PH.
- `done` is high in the first IDLE cycle after B_PH.
- `start` while busy is dropped: not queued, no error.
- Input changes on `delay` and `a_hold` after the start cycle have no effect.
- `b` is never high on two consecutive cycles. `a` and `b` are never high together.
- With `a_hold`=0, `a` is high for exactly one cycle per sequence.
- Reset asserted mid-sequence forces all outputs to 0 immediately (asynchronously) and returns to IDLE. After release the block waits for a fresh `start`.

## Timing
- `start` sampled at edge S gives:
  - `a`=1 in cycle S+1 (cycle T).
  - `b`=1 in cycle T+d.
  - `done`=1 in cycle T+d+1.
- `busy` is high for cycles T..T+d, which is d+1 cycles.
- Back-to-back: `start` high during the `done` cycle is accepted, and the next `a` follows in the cycle after. Minimum period is d+2 cycles.
- Latency from start to `b` is d+1 edges.

## Structure
- Package `delay_seq_pkg` holds:
  - `state_e` {IDLE, A_PH, WAIT, B_PH}
  - the clamp function `clamp_delay(delay, MAX_DELAY)`
- Sub-module `delay_down_counter`: a loadable down-counter of width DELAY_W with `load`, `load_val` and `en` inputs, plus `cnt` and `at_one` outputs. It uses the same clock and reset as the parent.
- The top level holds the FSM, the latched d and `a_hold`, and the output registers.

## Test plan
- d=1, `a_hold`=0, `start` at cycle 0 → `a`@1, `b`@2, `done`@3, `busy` high in cycles 1–2; a cover of `a ##1 b` hits.
- d=3, `a_hold`=1 → `a` high in cycles 1–3, `b`@4, `a` low @4, `done`@5; a cover of `a ##3 b` hits and `$rose(a) |=> a` holds.
- `delay`=0 gives behaviour identical to d=1. `delay`=15 with MAX_DELAY=8 → `b` 8 cycles after `a`.
- `start` pulsed in cycles 0, 2 and 3 with d=3 → exactly one sequence and one `done`. `start` in the `done` cycle (5) → second `a`@6, `b`@9.
- `rst_n` dropped in the WAIT cycle of a d=5 run → `a`, `b`, `busy` and `done` are 0 within the same cycle. No `b` after release until a new `start`; the new `start` produces a clean sequence.
- Random `start`, `delay` and `a_hold` over 10k cycles → `a`&&`b` is never 1, `b` never lasts 2 consecutive cycles, the count of `b` pulses equals the count of `done` pulses, and each `b` is exactly d cycles after the head `a`.
